// File: rtl/count_sequence_monitor.sv
// Watches a 2-bit odd/even counter for correct stepping, locks after LOCK_N good
// samples and counts sequencing errors seen while locked.
module count_sequence_monitor #(
    parameter int unsigned ERR_W  = 8,
    parameter int unsigned LOCK_N = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             select,
    input  logic [1:0]       count,
    input  logic             en,
    input  logic             clr,
    output logic             locked,
    output logic             fault,
    output logic [ERR_W-1:0] err_cnt,
    output logic             mode_chg,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StSync = 2'b01,
        StLock = 2'b10,
        StBad  = 2'b11
    } state_e;

    localparam logic [2:0] LockRun = 3'(LOCK_N);

    state_e             state_q, state_d;
    logic               sel_q, c1_q;
    logic [2:0]         run_q, run_d;
    logic               miss_q, miss_d;
    logic               fault_q, fault_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               mode_chg_q, mode_chg_d;
    logic               locked_q, locked_d;
    logic               good;
    logic               count_err;

    // count[0] must match the mode in force last edge; count[1] must toggle every edge.
    assign good = (count[0] == sel_q) && (count[1] != c1_q);

    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        miss_d    = miss_q;
        err_d     = err_q;
        fault_d   = fault_q;
        count_err = 1'b0;

        if (!en) begin
            state_d = StIdle;
            run_d   = '0;
            miss_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StSync;
                    run_d   = '0;
                    miss_d  = 1'b0;
                end
                StSync: begin
                    if (good) begin
                        run_d = run_q + 3'd1;
                        if (run_q + 3'd1 == LockRun) begin
                            state_d = StLock;
                            miss_d  = 1'b0;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                StLock: begin
                    if (good) begin
                        miss_d = 1'b0;
                    end else begin
                        count_err = 1'b1;
                        if (miss_q) begin
                            state_d = StSync;
                            run_d   = '0;
                            miss_d  = 1'b0;
                        end else begin
                            miss_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    run_d   = '0;
                    miss_d  = 1'b0;
                end
            endcase
        end

        if (count_err) begin
            fault_d = 1'b1;
            if (err_q != '1) begin
                err_d = err_q + 1'b1;
            end
        end
        // Clear takes priority over a same-cycle error.
        if (clr) begin
            err_d   = '0;
            fault_d = 1'b0;
        end

        mode_chg_d = (select != sel_q) && (state_q != StIdle);
        locked_d   = (state_d == StLock);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            sel_q      <= 1'b0;
            c1_q       <= 1'b0;
            run_q      <= '0;
            miss_q     <= 1'b0;
            fault_q    <= 1'b0;
            err_q      <= '0;
            mode_chg_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= select;
            c1_q       <= count[1];
            run_q      <= run_d;
            miss_q     <= miss_d;
            fault_q    <= fault_d;
            err_q      <= err_d;
            mode_chg_q <= mode_chg_d;
            locked_q   <= locked_d;
        end
    end

    assign locked   = locked_q;
    assign fault    = fault_q;
    assign err_cnt  = err_q;
    assign mode_chg = mode_chg_q;
    assign state    = state_q;

endmodule

// File: doc/count_sequence_monitor.md
COUNT_SEQUENCE_MONITOR -- requirements
Module: count_sequence_monitor

Interface
REQ-001 Parameter ERR_W, default 8, SHALL set the error-counter width.
REQ-002 Parameter LOCK_N, default 3, SHALL set the consecutive good samples needed to lock (range 1..7).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-low (rst=0 resets).
REQ-005 select  input  1  SHALL be the odd/even mode select driven to the 2-bit counter (1=odd, 0=even).
REQ-006 count  input  2  SHALL be the 2-bit counter output under observation.
REQ-007 en  input  1  SHALL enable monitoring; 0 forces IDLE.
REQ-008 clr  input  1  SHALL synchronously clear err_cnt and fault.
REQ-009 locked  output  1  SHALL be high only in state LOCK.
REQ-010 fault  output  1  SHALL be a sticky flag set by any error counted in LOCK.
REQ-011 err_cnt  output  ERR_W  SHALL be the saturating count of errors detected in LOCK.
REQ-012 mode_chg  output  1  SHALL be a one-cycle pulse on a select transition.
REQ-013 state  output  2  SHALL expose the FSM state: IDLE=00, SYNC=01, LOCK=10.

Function
REQ-014 History registers sel_q and c1_q SHALL capture select and count[1] on every clock edge, in every state.
REQ-015 A sample SHALL be good iff count[0]==sel_q AND count[1]!=c1_q; otherwise bad.
REQ-016 All outputs SHALL be registered; status reflects the sample at the preceding edge (1-cycle latency).
REQ-017 IDLE: en=1 -> SYNC next edge; run counter held at 0.
REQ-018 SYNC: good sample increments run counter; bad sample resets it to 0; no errors counted.
REQ-019 SYNC -> LOCK at the edge where the run counter reaches LOCK_N.
REQ-020 LOCK: bad sample -> err_cnt+1 (saturate at 2^ERR_W-1), fault=1, miss counter+1.
REQ-021 LOCK: good sample -> miss counter cleared.
REQ-022 LOCK -> SYNC on the second consecutive bad sample (that sample is still counted); run counter reset to 0.
REQ-023 en=0 in any state -> IDLE next edge; err_cnt and fault held.
REQ-024 mode_chg SHALL be 1 for exactly one cycle after any edge where select!=sel_q and state!=IDLE.
REQ-025 clr=1 SHALL zero err_cnt and fault at the next edge; clr wins over a simultaneous increment.
REQ-026 clr SHALL NOT affect FSM state, run/miss counters or history registers.
REQ-027 err_cnt SHALL hold at all-ones once saturated until clr or reset.
REQ-028 Unused state encoding 11 SHALL return to IDLE next edge.

Reset
REQ-029 rst=0 SHALL immediately force state=IDLE, sel_q=0, c1_q=0, run=0, miss=0, locked=0, fault=0, err_cnt=0, mode_chg=0.
REQ-030 Reset asserted mid-LOCK SHALL abandon lock with no error counted; after release the FSM starts from IDLE.

Verification
REQ-031 Reset release, en=1, select=1, healthy counter (count 11,01,11,...) -> state SYNC then LOCK after 3 good samples; locked=1, err_cnt=0.
REQ-032 LOCK, one forced count[1] non-toggle -> err_cnt=1, fault=1, locked stays 1; next good sample clears miss.
REQ-033 LOCK, two consecutive bad samples -> err_cnt=2, state SYNC, locked=0; relock after 3 good samples.
REQ-034 LOCK, select 1->0 with healthy counter -> mode_chg one-cycle pulse, count[0] follows one cycle later, no error, locked held.
REQ-035 ERR_W=2, repeated single faults -> err_cnt saturates at 3; clr coincident with a fault -> err_cnt=0, fault=0.
REQ-036 rst=0 asynchronously mid-LOCK with err_cnt=5 -> all outputs zero immediately, state=IDLE.
